// File: rtl/arb_requester.sv
// Requester agent: queues burst jobs, requests the arbiter and moves one beat per granted cycle.
// Latency: a job pushed at edge N raises req after edge N+1; the first beat can follow in that same cycle.
// Backpressure: job_ready drops when the queue is full; a missing grant stalls the burst with req held.
//
// Ports: clk/reset (sync, active-high); job_valid/job_len/job_ready job intake;
//        req/grant arbiter handshake; beat/beat_idx/last per-beat strobes;
//        busy, err_grant_lost (sticky) and jobs_done (wrapping) status.
module arb_requester #(
   parameter int DEPTH = 4,
   parameter int LEN_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             job_valid,
   input  logic [LEN_W-1:0] job_len,
   output logic             job_ready,
   output logic             req,
   input  logic             grant,
   output logic             beat,
   output logic [LEN_W-1:0] beat_idx,
   output logic             last,
   output logic             busy,
   output logic             err_grant_lost,
   output logic [CNT_W-1:0] jobs_done
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW    = PTR_W + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_XFER = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic [1:0]       state_q,  state_d;
   logic [LEN_W-1:0] mem_q [DEPTH];
   logic [LEN_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic [LEN_W-1:0] idx_q,    idx_d;
   logic             err_q,    err_d;
   logic [CNT_W-1:0] done_q,   done_d;

   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic             active;
   logic [LEN_W-1:0] final_idx;

   assign full      = (cnt_q == FULL_CNT);
   assign empty     = (cnt_q == '0);
   // Readiness only looks at full, never at a same-cycle pop, so it stays a
   // registered-state decode with no path from grant.
   assign job_ready = !full && !reset;
   assign push      = job_valid && job_ready;

   // len==0 encodes 2**LEN_W beats; subtracting 1 with wraparound yields the
   // all-ones final index for that case with no special handling.
   assign final_idx = mem_q[rd_ptr_q] - LEN_W'(1);

   assign active    = (state_q == S_REQ) || (state_q == S_XFER);
   assign req       = active;
   assign beat      = active && grant && !reset;
   assign last      = beat && (idx_q == final_idx);
   assign pop       = last;

   assign beat_idx       = idx_q;
   assign busy           = !empty || (state_q != S_IDLE);
   assign err_grant_lost = err_q;
   assign jobs_done      = done_q;

   // Job queue
   always_comb begin
      mem_d = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = job_len;
      end
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Handshake FSM and beat counter
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_d   = err_q || ((state_q == S_XFER) && !grant);
      done_d  = done_q + CNT_W'(last);
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               state_d = S_REQ;
            end
         end
         S_REQ, S_XFER: begin
            if (beat) begin
               if (last) begin
                  state_d = S_GAP;
                  idx_d   = '0;
               end else begin
                  state_d = S_XFER;
                  idx_d   = idx_q + LEN_W'(1);
               end
            end
         end
         // One req-low cycle; a job arriving during it still counts as pending.
         S_GAP: begin
            state_d = (!empty || push) ? S_REQ : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         idx_q    <= '0;
         err_q    <= 1'b0;
         done_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   // Queue storage holds no control state, so it needs no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: tb/tb_arb_requester.sv
module tb_arb_requester;

   logic       clk = 1'b0;
   logic       rst;
   logic       jv_a, jv_b;
   logic [3:0] jl_a, jl_b;
   logic       g_tb;
   logic       arb_mode;
   logic       req_a, req_b, grant_a, grant_b;
   logic       beat_a, beat_b, last_a, last_b;
   logic [3:0] idx_a, idx_b;
   logic       rdy_a, rdy_b, busy_a, busy_b, err_a, err_b;
   logic [7:0] done_a, done_b;

   int n_applied = 0;
   int n_miss    = 0;

   always #5 clk = ~clk;

   // Reference two-way arbiter: locks onto the current owner while it keeps
   // req high, otherwise alternates priority between the clients.
   logic [1:0] lock_q;
   logic       prio_q;
   logic       arb_ga, arb_gb;
   assign arb_ga = req_a && ((lock_q == 2'd1) || ((lock_q == 2'd0) && (!req_b || !prio_q)));
   assign arb_gb = req_b && !arb_ga && ((lock_q == 2'd2) || (lock_q == 2'd0));
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_q <= 2'd0;
         prio_q <= 1'b0;
      end else begin
         lock_q <= arb_ga ? 2'd1 : (arb_gb ? 2'd2 : 2'd0);
         prio_q <= arb_ga ? 1'b1 : (arb_gb ? 1'b0 : prio_q);
      end
   end
   assign grant_a = arb_mode ? arb_ga : g_tb;
   assign grant_b = arb_gb;

   arb_requester #(.DEPTH(4), .LEN_W(4), .CNT_W(8)) u_a (
      .clk(clk), .reset(rst), .job_valid(jv_a), .job_len(jl_a), .job_ready(rdy_a),
      .req(req_a), .grant(grant_a), .beat(beat_a), .beat_idx(idx_a), .last(last_a),
      .busy(busy_a), .err_grant_lost(err_a), .jobs_done(done_a));

   arb_requester #(.DEPTH(4), .LEN_W(4), .CNT_W(8)) u_b (
      .clk(clk), .reset(rst), .job_valid(jv_b), .job_len(jl_b), .job_ready(rdy_b),
      .req(req_b), .grant(grant_b), .beat(beat_b), .beat_idx(idx_b), .last(last_b),
      .busy(busy_b), .err_grant_lost(err_b), .jobs_done(done_b));

   typedef struct packed {
      logic       rst;
      logic       jv;
      logic [3:0] jl;
      logic       gnt;
      logic       req;
      logic       beat;
      logic [3:0] idx;
      logic       last;
      logic       rdy;
      logic       busy;
      logic       err;
      logic [7:0] done;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic jv, input logic [3:0] jl, input logic g,
                               input logic rq, input logic bt, input logic [3:0] ix, input logic ls,
                               input logic rd, input logic bs, input logic er, input logic [7:0] dn);
      vec_t v;
      v = '{rst:r, jv:jv, jl:jl, gnt:g, req:rq, beat:bt, idx:ix, last:ls,
            rdy:rd, busy:bs, err:er, done:dn};
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drv(input logic r, input logic jv, input logic [3:0] jl, input logic g);
      rst  = r;
      jv_a = jv;
      jl_a = jl;
      g_tb = g;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drv(1'b1, 1'b0, 4'd0, 1'b0);
      jv_b = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int cnt, bad, last_idx, pushed, acc, acc_a, acc_b, exp_beats_a, exp_beats_b;
      int beats_a, beats_b, overlap, quiet;
      bit seen;
      logic [3:0] len_a, len_b;

      arb_mode = 1'b0;
      jv_b = 1'b0;
      jl_b = 4'd0;
      drv(1'b1, 1'b0, 4'd0, 1'b0);
      repeat (2) @(posedge clk);

      // reset, one 3-beat job
      vecs.push_back(mk(1,0,0,0, 0,0,0,0,0,0,0,0));
      vecs.push_back(mk(0,1,3,1, 0,0,0,0,1,0,0,0));
      vecs.push_back(mk(0,0,0,1, 0,0,0,0,1,1,0,0));
      vecs.push_back(mk(0,0,0,1, 1,1,0,0,1,1,0,0));
      vecs.push_back(mk(0,0,0,1, 1,1,1,0,1,1,0,0));
      vecs.push_back(mk(0,0,0,1, 1,1,2,1,1,1,0,0));
      vecs.push_back(mk(0,0,0,1, 0,0,0,0,1,1,0,1));
      vecs.push_back(mk(0,0,0,1, 0,0,0,0,1,0,0,1));
      // two single-beat jobs back to back
      vecs.push_back(mk(0,1,1,1, 0,0,0,0,1,0,0,1));
      vecs.push_back(mk(0,1,1,1, 0,0,0,0,1,1,0,1));
      vecs.push_back(mk(0,0,0,1, 1,1,0,1,1,1,0,1));
      vecs.push_back(mk(0,0,0,1, 0,0,0,0,1,1,0,2));
      vecs.push_back(mk(0,0,0,1, 1,1,0,1,1,1,0,2));
      vecs.push_back(mk(0,0,0,1, 0,0,0,0,1,1,0,3));
      vecs.push_back(mk(0,0,0,1, 0,0,0,0,1,0,0,3));
      // 4-beat job, grant withdrawn for two cycles after the first beat
      vecs.push_back(mk(0,1,4,0, 0,0,0,0,1,0,0,3));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,1,1,0,3));
      vecs.push_back(mk(0,0,0,1, 1,1,0,0,1,1,0,3));
      vecs.push_back(mk(0,0,0,0, 1,0,1,0,1,1,0,3));
      vecs.push_back(mk(0,0,0,0, 1,0,1,0,1,1,1,3));
      vecs.push_back(mk(0,0,0,1, 1,1,1,0,1,1,1,3));
      vecs.push_back(mk(0,0,0,1, 1,1,2,0,1,1,1,3));
      vecs.push_back(mk(0,0,0,1, 1,1,3,1,1,1,1,3));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,1,1,1,4));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,1,0,1,4));
      // fill the queue with grant low, fifth offer refused, then pop while full
      vecs.push_back(mk(0,1,2,0, 0,0,0,0,1,0,1,4));
      vecs.push_back(mk(0,1,2,0, 0,0,0,0,1,1,1,4));
      vecs.push_back(mk(0,1,2,0, 1,0,0,0,1,1,1,4));
      vecs.push_back(mk(0,1,2,0, 1,0,0,0,1,1,1,4));
      vecs.push_back(mk(0,1,2,0, 1,0,0,0,0,1,1,4));
      vecs.push_back(mk(0,0,0,0, 1,0,0,0,0,1,1,4));
      vecs.push_back(mk(0,0,0,0, 1,0,0,0,0,1,1,4));
      vecs.push_back(mk(0,0,0,1, 1,1,0,0,0,1,1,4));
      vecs.push_back(mk(0,1,5,1, 1,1,1,1,0,1,1,4));
      vecs.push_back(mk(0,0,0,0, 0,0,0,0,1,1,1,5));
      vecs.push_back(mk(0,0,0,0, 1,0,0,0,1,1,1,5));

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drv(vecs[i].rst, vecs[i].jv, vecs[i].jl, vecs[i].gnt);
         #1;
         chk($sformatf("vec%0d", i),
             64'({req_a, beat_a, idx_a, last_a, rdy_a, busy_a, err_a, done_a}),
             64'({vecs[i].req, vecs[i].beat, vecs[i].idx, vecs[i].last,
                  vecs[i].rdy, vecs[i].busy, vecs[i].err, vecs[i].done}));
      end

      // reset while requesting with grant high: no beat, queue closed
      @(negedge clk);
      drv(1'b1, 1'b0, 4'd0, 1'b1);
      #1;
      chk("rst_beat_rdy", 64'({beat_a, rdy_a}), 64'(2'b00));
      @(negedge clk);
      drv(1'b0, 1'b0, 4'd0, 1'b0);
      #1;
      chk("post_rst", 64'({req_a, busy_a, rdy_a, err_a, done_a}), 64'({4'b0010, 8'd0}));

      // full-length (len=0) job: 16 beats, index 0..15, last on 15
      @(negedge clk);
      drv(1'b0, 1'b1, 4'd0, 1'b1);
      cnt = 0; bad = 0; last_idx = -1; seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         jv_a = 1'b0;
         #1;
         if (beat_a) begin
            if (int'(idx_a) != cnt) bad++;
            cnt++;
            if (last_a) begin
               last_idx = int'(idx_a);
               seen = 1;
            end
         end
      end
      chk("full_len_beats", 64'(cnt), 64'd16);
      chk("full_len_last_idx", 64'(last_idx), 64'd15);
      chk("full_len_idx_seq", 64'(bad), 64'd0);
      @(negedge clk);
      #1;
      chk("full_len_done", 64'(done_a), 64'd1);

      // reset during beat idx 2 of a 16-beat job with two more queued
      do_reset();
      drv(1'b0, 1'b1, 4'd0, 1'b1);
      @(negedge clk);
      jl_a = 4'd2;
      @(negedge clk);
      jl_a = 4'd3;
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         jv_a = 1'b0;
         #1;
         if (beat_a && idx_a == 4'd2) seen = 1;
      end
      chk("mid_burst_reached", 64'(seen), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid_burst_rst_beat", 64'(beat_a), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_burst_after", 64'({req_a, busy_a, rdy_a, done_a}), 64'({3'b001, 8'd0}));
      quiet = 0;
      repeat (4) begin
         @(negedge clk);
         #1;
         if (req_a || busy_a || beat_a) quiet++;
      end
      chk("work_discarded", 64'(quiet), 64'd0);

      // jobs_done wraps: 260 single-beat jobs
      do_reset();
      g_tb = 1'b1;
      pushed = 0;
      for (int c = 0; c < 3000 && (pushed < 260 || busy_a); c++) begin
         @(negedge clk);
         jv_a = (pushed < 260);
         jl_a = 4'd1;
         #1;
         if (jv_a && rdy_a) pushed++;
      end
      chk("wrap_pushed", 64'(pushed), 64'd260);
      chk("wrap_drained", 64'(busy_a), 64'd0);
      chk("wrap_done", 64'(done_a), 64'd4);
      chk("wrap_no_err", 64'(err_a), 64'd0);

      // two instances sharing the arbiter, 32 random pushes
      do_reset();
      arb_mode = 1'b1;
      acc = 0; acc_a = 0; acc_b = 0; exp_beats_a = 0; exp_beats_b = 0;
      beats_a = 0; beats_b = 0; overlap = 0;
      for (int c = 0; c < 5000 && (acc < 32 || busy_a || busy_b); c++) begin
         @(negedge clk);
         len_a = 4'($urandom_range(0, 15));
         len_b = 4'($urandom_range(0, 15));
         jv_a = (acc < 32) && ($urandom_range(0, 1) == 1);
         jv_b = (acc + int'(jv_a) < 32) && ($urandom_range(0, 1) == 1);
         jl_a = len_a;
         jl_b = len_b;
         #1;
         if (grant_a && grant_b) overlap++;
         if (beat_a) beats_a++;
         if (beat_b) beats_b++;
         if (jv_a && rdy_a) begin
            acc++; acc_a++;
            exp_beats_a += (len_a == 4'd0) ? 16 : int'(len_a);
         end
         if (jv_b && rdy_b) begin
            acc++; acc_b++;
            exp_beats_b += (len_b == 4'd0) ? 16 : int'(len_b);
         end
      end
      jv_a = 1'b0;
      jv_b = 1'b0;
      chk("pair_accepted", 64'(acc), 64'd32);
      chk("pair_drained", 64'({busy_a, busy_b}), 64'd0);
      chk("pair_grant_overlap", 64'(overlap), 64'd0);
      chk("pair_done_a", 64'(done_a), 64'(acc_a % 256));
      chk("pair_done_b", 64'(done_b), 64'(acc_b % 256));
      chk("pair_beats_a", 64'(beats_a), 64'(exp_beats_a));
      chk("pair_beats_b", 64'(beats_b), 64'(exp_beats_b));
      chk("pair_no_err", 64'({err_a, err_b}), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end

endmodule
